// File: rtl/slice_scheduler.sv
// Fruit-slice scan engine: evaluates one fruit slot per cycle against a latched
// cursor and reports each hit through a valid/ready handshake.
module slice_scheduler #(
    parameter int NSLOT = 4,
    parameter int HALF  = 8,
    parameter int DIAG  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [9:0]            cur_x,
    input  logic [9:0]            cur_y,
    input  logic                  cur_en,
    input  logic [10*NSLOT-1:0]   fruit_x,
    input  logic [10*NSLOT-1:0]   fruit_y,
    input  logic [NSLOT-1:0]      fruit_act,
    output logic                  slice_valid,
    output logic [2:0]            slice_id,
    input  logic                  slice_ready,
    output logic [NSLOT-1:0]      hit_mask,
    output logic [7:0]            score,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT, FINISH} state_t;

    localparam logic [10:0] HALF_W = 11'(HALF);
    localparam logic [2:0]  LAST   = 3'(NSLOT - 1);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [NSLOT-1:0] acc_q, acc_d;
    logic [9:0]       cx_q, cx_d, cy_q, cy_d;
    logic             cen_q, cen_d;
    logic             slice_valid_q, slice_valid_d;
    logic [2:0]       slice_id_q, slice_id_d;
    logic [NSLOT-1:0] hit_mask_q, hit_mask_d;
    logic [7:0]       score_q, score_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;

    logic [9:0]       fx, fy;
    logic             act;
    logic [NSLOT-1:0] sel;
    logic [10:0]      lo_x, hi_x, lo_y, hi_y;
    logic             in_win, diag_ok, hit;

    function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Window test for the slot under the scan index; slot data is read live.
    always_comb begin
        fx  = '0;
        fy  = '0;
        act = 1'b0;
        sel = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (idx_q == 3'(i)) begin
                fx     = fruit_x[10*i +: 10];
                fy     = fruit_y[10*i +: 10];
                act    = fruit_act[i];
                sel[i] = 1'b1;
            end
        end
        lo_x    = ({1'b0, fx} < HALF_W) ? '0 : ({1'b0, fx} - HALF_W);
        lo_y    = ({1'b0, fy} < HALF_W) ? '0 : ({1'b0, fy} - HALF_W);
        hi_x    = {1'b0, fx} + HALF_W;
        hi_y    = {1'b0, fy} + HALF_W;
        in_win  = ({1'b0, cx_q} > lo_x) && ({1'b0, cx_q} < hi_x) &&
                  ({1'b0, cy_q} > lo_y) && ({1'b0, cy_q} < hi_y);
        diag_ok = (DIAG == 0) || (absdiff(cx_q, fx) == absdiff(cy_q, fy));
        hit     = act && cen_q && in_win && diag_ok;
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        cen_d         = cen_q;
        slice_valid_d = slice_valid_q;
        slice_id_d    = slice_id_q;
        hit_mask_d    = hit_mask_q;
        score_d       = score_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        overrun_d     = overrun_q;

        if (frame_start && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    cx_d    = cur_x;
                    cy_d    = cur_y;
                    cen_d   = cur_en;
                    idx_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    acc_d         = acc_q | sel;
                    slice_valid_d = 1'b1;
                    slice_id_d    = idx_q;
                    state_d       = REPORT;
                end else if (idx_q == LAST) begin
                    hit_mask_d = acc_q;
                    done_d     = 1'b1;
                    state_d    = FINISH;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            REPORT: begin
                if (slice_ready) begin
                    slice_valid_d = 1'b0;
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                    if (idx_q == LAST) begin
                        hit_mask_d = acc_q;
                        done_d     = 1'b1;
                        state_d    = FINISH;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SCAN;
                    end
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered so done and hit_mask appear together on the FINISH cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            acc_q         <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            cen_q         <= 1'b0;
            slice_valid_q <= 1'b0;
            slice_id_q    <= '0;
            hit_mask_q    <= '0;
            score_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            cen_q         <= cen_d;
            slice_valid_q <= slice_valid_d;
            slice_id_q    <= slice_id_d;
            hit_mask_q    <= hit_mask_d;
            score_q       <= score_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign slice_valid = slice_valid_q;
    assign slice_id    = slice_id_q;
    assign hit_mask    = hit_mask_q;
    assign score       = score_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_slice_scheduler.sv
// Scoreboard bench for slice_scheduler: stimulus queues expected slice events and
// frame results; a negedge monitor pops and compares them as the DUT produces them.
module tb_slice_scheduler;

    logic        clk, rst_n, frame_start, cur_en, slice_ready;
    logic [9:0]  cur_x, cur_y;
    logic [39:0] fruit_x, fruit_y;
    logic [3:0]  fruit_act;
    logic        slice_valid, busy, done, overrun;
    logic [2:0]  slice_id;
    logic [3:0]  hit_mask;
    logic [7:0]  score;
    logic        d0_valid, d0_busy, d0_done, d0_overrun;
    logic [2:0]  d0_id;
    logic [3:0]  d0_hit_mask;
    logic [7:0]  d0_score;

    slice_scheduler #(.NSLOT(4), .HALF(8), .DIAG(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .cur_x(cur_x), .cur_y(cur_y), .cur_en(cur_en),
        .fruit_x(fruit_x), .fruit_y(fruit_y), .fruit_act(fruit_act),
        .slice_valid(slice_valid), .slice_id(slice_id), .slice_ready(slice_ready),
        .hit_mask(hit_mask), .score(score), .busy(busy), .done(done), .overrun(overrun)
    );

    // Same stimulus with the diagonal constraint disabled.
    slice_scheduler #(.NSLOT(4), .HALF(8), .DIAG(0)) u_dut_nodiag (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .cur_x(cur_x), .cur_y(cur_y), .cur_en(cur_en),
        .fruit_x(fruit_x), .fruit_y(fruit_y), .fruit_act(fruit_act),
        .slice_valid(d0_valid), .slice_id(d0_id), .slice_ready(1'b1),
        .hit_mask(d0_hit_mask), .score(d0_score), .busy(d0_busy), .done(d0_done),
        .overrun(d0_overrun)
    );

    typedef struct { int id; int vcycles; } ev_t;
    typedef struct { int mask; int score; int bcycles; } fr_t;

    ev_t ev_q[$];
    fr_t fr_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_score = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_slot(input int i, input int x, input int y, input logic a);
        fruit_x[10*i +: 10] = 10'(x);
        fruit_y[10*i +: 10] = 10'(y);
        fruit_act[i]        = a;
    endtask

    task automatic clear_slots();
        fruit_x   = '0;
        fruit_y   = '0;
        fruit_act = '0;
    endtask

    task automatic push_ev(input int id, input int vc);
        ev_t e;
        e.id = id; e.vcycles = vc;
        ev_q.push_back(e);
    endtask

    task automatic push_fr(input int mask, input int hits, input int bc);
        fr_t f;
        exp_score = (exp_score + hits > 255) ? 255 : exp_score + hits;
        f.mask = mask; f.score = exp_score; f.bcycles = bc;
        fr_q.push_back(f);
    endtask

    // Called at posedge+#1; the pulse is accepted on the next rising edge.
    task automatic start_frame(input int x, input int y, input logic en);
        cur_x = 10'(x); cur_y = 10'(y); cur_en = en;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!busy) return;
        end
        check("wait_idle_timeout", busy, 0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (slice_valid) return;
        end
        check("wait_valid_timeout", slice_valid, 1);
    endtask

    // Monitor: slice handshakes, stall stability, and per-frame results on busy fall.
    initial begin
        int vcnt, bcnt, dcnt;
        logic prev_v, prev_rdy, prev_busy;
        logic [2:0] prev_id;
        ev_t e;
        fr_t f;
        vcnt = 0; bcnt = 0; dcnt = 0;
        prev_v = 1'b0; prev_rdy = 1'b0; prev_busy = 1'b0; prev_id = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                vcnt = 0; bcnt = 0; dcnt = 0;
                prev_v = 1'b0; prev_rdy = 1'b0; prev_busy = 1'b0;
            end else begin
                if (prev_v && !prev_rdy)
                    check("stall_hold", {slice_valid, slice_id}, {1'b1, prev_id});
                if (slice_valid) begin
                    vcnt++;
                    if (slice_ready) begin
                        if (ev_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_slice: got id %0d expected none", slice_id);
                        end else begin
                            e = ev_q.pop_front();
                            check("slice_id", slice_id, e.id);
                            check("valid_cycles", vcnt, e.vcycles);
                        end
                        vcnt = 0;
                    end
                end
                if (busy) bcnt++;
                if (done) dcnt++;
                if (prev_busy && !busy) begin
                    if (fr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_frame: got mask %0d expected none", hit_mask);
                    end else begin
                        f = fr_q.pop_front();
                        check("hit_mask", hit_mask, f.mask);
                        check("score", score, f.score);
                        check("busy_cycles", bcnt, f.bcycles);
                        check("done_pulses", dcnt, 1);
                    end
                    bcnt = 0; dcnt = 0;
                end
                prev_v = slice_valid; prev_rdy = slice_ready;
                prev_busy = busy; prev_id = slice_id;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dseen;
        rst_n = 1'b0; frame_start = 1'b0; slice_ready = 1'b1;
        cur_x = '0; cur_y = '0; cur_en = 1'b0;
        clear_slots();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", slice_valid, 0);
        check("rst_id", slice_id, 0);
        check("rst_mask", hit_mask, 0);
        check("rst_score", score, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);

        // Single hit on slot 1, frame issued on the first edge after reset release.
        set_slot(1, 96, 96, 1'b1);
        push_ev(1, 1); push_fr(4'b0010, 1, 6);
        rst_n = 1'b1;
        start_frame(100, 100, 1'b1);
        wait_idle();

        // dx=4, dy=7: only the non-diagonal instance hits.
        clear_slots(); set_slot(0, 96, 96, 1'b1);
        push_fr(4'b0000, 0, 5);
        start_frame(100, 103, 1'b1);
        wait_idle();
        repeat (2) begin @(posedge clk); #1; end
        check("nodiag_mask", d0_hit_mask, 4'b0001);

        // Two hits, first event stalled for 5 cycles.
        clear_slots();
        set_slot(0, 195, 195, 1'b1); set_slot(1, 300, 300, 1'b1); set_slot(2, 205, 205, 1'b1);
        push_ev(0, 6); push_ev(2, 1); push_fr(4'b0101, 2, 12);
        slice_ready = 1'b0;
        start_frame(200, 200, 1'b1);
        wait_valid();
        repeat (5) begin @(posedge clk); #1; end
        slice_ready = 1'b1;
        wait_idle();

        // Low-edge clamp: lo=0 with strict compare.
        clear_slots(); set_slot(0, 3, 3, 1'b1);
        push_fr(4'b0000, 0, 5);
        start_frame(0, 0, 1'b1);
        wait_idle();
        push_ev(0, 1); push_fr(4'b0001, 1, 6);
        start_frame(1, 1, 1'b1);
        wait_idle();

        // Overrun and cursor isolation during a scan.
        check("overrun_pre", overrun, 0);
        clear_slots(); set_slot(3, 50, 50, 1'b1);
        push_ev(3, 1); push_fr(4'b1000, 1, 6);
        start_frame(50, 50, 1'b1);
        cur_x = 10'd900; cur_y = 10'd900; cur_en = 1'b0;
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        wait_idle();
        check("overrun_set", overrun, 1);

        // Drive score into saturation with four-hit frames.
        for (int k = 0; k < 4; k++) set_slot(k, 50, 50, 1'b1);
        while (exp_score < 255) begin
            for (int k = 0; k < 4; k++) push_ev(k, 1);
            push_fr(4'b1111, 4, 9);
            start_frame(50, 50, 1'b1);
            wait_idle();
        end
        clear_slots(); set_slot(0, 50, 50, 1'b1);
        push_ev(0, 1); push_fr(4'b0001, 1, 6);
        start_frame(50, 50, 1'b1);
        wait_idle();
        check("overrun_sticky", overrun, 1);

        // Reset in the middle of REPORT.
        slice_ready = 1'b0;
        start_frame(50, 50, 1'b1);
        wait_valid();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", slice_valid, 0);
        check("midrst_id", slice_id, 0);
        check("midrst_mask", hit_mask, 0);
        check("midrst_score", score, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_overrun", overrun, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; slice_ready = 1'b1;
        dseen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy || slice_valid) dseen++;
        end
        check("post_rst_quiet", dseen, 0);
        check("post_rst_score", score, 0);

        check("ev_q_empty", ev_q.size(), 0);
        check("fr_q_empty", fr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slice_scheduler.md
SLICE_SCHEDULER -- requirements
Module: slice_scheduler

Interface
REQ-001 Parameter NSLOT, 4, number of fruit slots scanned per frame (2..8).
REQ-002 Parameter HALF, 8, half-width of the square hit window in pixels.
REQ-003 Parameter DIAG, 1, when 1 a hit also requires |dx|==|dy| (diagonal blade line); when 0 the window test alone decides.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 frame_start  input  1  one-cycle pulse requesting a scan of all slots.
REQ-007 cur_x, cur_y  input  10 each  cursor position, sampled at accepted frame_start.
REQ-008 cur_en  input  1  cursor pressed, sampled with cur_x/cur_y.
REQ-009 fruit_x, fruit_y  input  10*NSLOT each  packed slot centres; slot i at bits [10i+9:10i].
REQ-010 fruit_act  input  NSLOT  slot occupied flags.
REQ-011 slice_valid  output  1  a slice event is presented.
REQ-012 slice_id  output  3  slot index of the presented event.
REQ-013 slice_ready  input  1  consumer accepts the event when high with slice_valid.
REQ-014 hit_mask  output  NSLOT  slots sliced in the most recent completed scan.
REQ-015 score  output  8  running count of accepted slices.
REQ-016 busy  output  1  high from accepted frame_start until scan completion.
REQ-017 done  output  1  one-cycle pulse when a scan completes.
REQ-018 overrun  output  1  sticky flag, frame_start arrived while busy.

Function
REQ-019 States IDLE, SCAN, REPORT, FINISH; reset state IDLE.
REQ-020 IDLE: frame_start -> latch cur_x/cur_y/cur_en into registers, clear slot index and scan-mask accumulator, go SCAN next cycle; busy high from that next cycle.
REQ-021 SCAN: one slot per cycle, index 0..NSLOT-1 ascending; fruit_x/fruit_y/fruit_act read live in the cycle the slot is evaluated.
REQ-022 Window bounds: lo = 0 if centre < HALF else centre-HALF; hi = centre+HALF computed in 11 bits (no wrap).
REQ-023 Hit = fruit_act[i] AND latched cur_en AND lo_x < cur_x < hi_x AND lo_y < cur_y < hi_y (strict) AND (DIAG==0 OR |cur_x-fx|==|cur_y-fy|).
REQ-024 On hit: set accumulator bit i, go REPORT with slice_valid=1, slice_id=i; on miss: advance index.
REQ-025 REPORT: slice_valid and slice_id held stable until slice_valid&&slice_ready; on that cycle score increments (saturates at 255), then resume SCAN at index i+1 or go FINISH if i was last.
REQ-026 Miss on last slot -> FINISH.
REQ-027 FINISH: hit_mask <= accumulator, done=1 for exactly one cycle, busy drops, return IDLE; frame_start in FINISH counts as busy.
REQ-028 Scan latency with no hits: busy high exactly NSLOT+1 cycles; each hit adds 1 cycle plus ready stall cycles.
REQ-029 frame_start while busy is ignored and sets overrun; overrun clears only on reset.
REQ-030 Cursor registers unaffected by cur_x/cur_y changes during a scan.
REQ-031 hit_mask holds its value between scans; unchanged until the next FINISH.

Reset
REQ-032 rst_n low asynchronously forces IDLE, slice_valid=0, slice_id=0, hit_mask=0, score=0, busy=0, done=0, overrun=0, latched cursor=0.
REQ-033 Reset asserted mid-scan or mid-REPORT abandons the scan; no score increment, no done pulse after release.
REQ-034 First frame_start is accepted on the first clock edge after rst_n deasserts.

Verification
REQ-035 NSLOT=4, cursor (100,100) en=1, slot1 at (96,96) active, others inactive, ready=1 -> one slice_valid id=1, score 0->1, hit_mask=0010, done one cycle, busy 6 cycles.
REQ-036 Cursor (100,103), slot0 (96,96), DIAG=1 -> no hit (dx=4, dy=7); same with DIAG=0 -> hit on slot0.
REQ-037 Slots 0 and 2 both hit, slice_ready held low 5 cycles on first event -> slice_valid/slice_id=0 stable 5 cycles, then id=2, score +2, hit_mask=0101.
REQ-038 Slot at (3,3), cursor (0,0) -> lo clamps to 0, strict compare gives no hit; cursor (1,1) -> hit.
REQ-039 frame_start pulsed on cycle 2 of a scan -> ignored, overrun=1 and stays 1; scan results unchanged.
REQ-040 score preset to 255 via 255 accepted slices, one more hit -> score stays 255; rst_n low mid-REPORT -> all outputs zero immediately.
